fusion_integrator_mc: RTL

- Parametrised, multi-channel complementary-filter angle estimator, a successor to the single-pair incline/roll integrator.
- Each channel integrates an offset-compensated gyro rate and leaks it toward an angle derived from the accelerometer.
- One shared multiplier serves all channels, time-multiplexed by an FSM.
- Adds run-time gyro offset calibration, saturating integrators, hysteretic lean-zeroing and overrun detection. Sits between inert_intf and the assist/incline consumers.

---
 rtl/fusion_integrator_mc_if.sv | 27 ++
 rtl/fusion_integrator_mc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fusion_integrator_mc_if.sv
// rtl/fusion_integrator_mc_if.sv - sample/result bundle between the inertial front end and the angle estimator
interface fusion_integrator_mc_if #(
    parameter int NCH = 2,
    parameter int DW  = 16,
    parameter int OW  = 13
);
    logic                vld;
    logic [NCH*DW-1:0]   rate;
    logic [NCH*DW-1:0]   accel;
    logic                cal_start;
    logic [NCH*OW-1:0]   angle;
    logic                out_vld;
    logic                zeroed;
    logic                cal_busy;
    logic [NCH-1:0]      sat;
    logic                overrun;

    modport master (
        output vld, rate, accel, cal_start,
        input  angle, out_vld, zeroed, cal_busy, sat, overrun
    );

    modport slave (
        input  vld, rate, accel, cal_start,
        output angle, out_vld, zeroed, cal_busy, sat, overrun
    );
endinterface

// File: rtl/fusion_integrator_mc.sv
// rtl/fusion_integrator_mc.sv - multi-channel complementary-filter angle estimator on one shared multiplier
module fusion_integrator_mc #(
    parameter int NCH        = 2,
    parameter int DW         = 16,
    parameter int IW         = 24,
    parameter int SHIFT      = 11,
    parameter int ACC_GAIN   = 327,
    parameter int GAIN_SHIFT = 13,
    parameter int LEAK       = 1024,
    parameter logic [DW-1:0] OFFSET_INIT = DW'(16'h0054),
    parameter int CAL_LOG    = 4,
    parameter int ZERO_CH    = 0,
    parameter int GATE_CH    = 1,
    parameter int THRES      = 152,
    parameter int HYST       = 16
) (
    input logic clk,
    input logic rst,
    fusion_integrator_mc_if.slave bus
);
    localparam int OW = IW - SHIFT;
    localparam int PW = DW + 11;
    localparam int SW = DW + CAL_LOG;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_UPD  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic signed [10:0]   GAIN_S  = 11'(ACC_GAIN);
    localparam logic signed [IW-1:0] LEAK_P  = IW'(LEAK);
    localparam logic signed [IW-1:0] LEAK_N  = IW'(-LEAK);
    localparam logic signed [IW-1:0] INT_MAX = {1'b0, {(IW-1){1'b1}}};
    localparam logic signed [IW-1:0] INT_MIN = {1'b1, {(IW-1){1'b0}}};
    localparam logic signed [OW-1:0] ANG_MIN = {1'b1, {(OW-1){1'b0}}};
    localparam logic [OW-1:0]        ANG_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0]        THR_HI  = OW'(THRES);
    localparam logic [OW-1:0]        THR_LO  = OW'(THRES - HYST);
    localparam logic [CAL_LOG:0]     CAL_N   = {1'b1, {CAL_LOG{1'b0}}};
    localparam logic [CAL_LOG:0]     CNT_ONE = (CAL_LOG+1)'(1);

    logic [1:0]              state;
    logic [CW-1:0]           ch;
    logic [NCH*DW-1:0]       smp_rate;
    logic [NCH*DW-1:0]       smp_accel;
    logic signed [PW-1:0]    prod;
    logic signed [IW-1:0]    integ [NCH];
    logic signed [OW-1:0]    ang   [NCH];
    logic signed [DW-1:0]    off   [NCH];
    logic signed [SW-1:0]    sum   [NCH];
    logic [CAL_LOG:0]        cal_cnt;
    logic                    out_vld_r, zeroed_r, cal_busy_r, overrun_r;
    logic [NCH-1:0]          sat_r;

    logic                    accept;
    logic signed [DW-1:0]    cur_rate, cur_accel, cur_off;
    logic signed [OW-1:0]    acc_ang, cur_ang, gate_ang;
    logic signed [IW-1:0]    diff, step, nxt;
    logic signed [IW:0]      raw;
    logic                    clamp;
    logic [OW-1:0]           gate_mag;
    logic                    prod_unused;

    assign accept    = (state == S_IDLE) && bus.vld;
    assign cur_rate  = smp_rate[int'(ch)*DW +: DW];
    assign cur_accel = smp_accel[int'(ch)*DW +: DW];
    assign cur_off   = off[ch];
    assign acc_ang   = prod[GAIN_SHIFT +: OW];
    assign cur_ang   = integ[ch][IW-1:SHIFT];
    assign prod_unused = ^{prod[PW-1], prod[GAIN_SHIFT-1:0]};

    // Full-width rate difference, then one signed leak step toward the accel angle.
    assign diff  = {{(IW-DW){cur_rate[DW-1]}}, cur_rate} - {{(IW-DW){cur_off[DW-1]}}, cur_off};
    assign step  = diff + ((acc_ang > cur_ang) ? LEAK_P : LEAK_N);
    assign raw   = {integ[ch][IW-1], integ[ch]} + {step[IW-1], step};
    assign clamp = raw[IW] ^ raw[IW-1];
    assign nxt   = clamp ? (raw[IW] ? INT_MIN : INT_MAX) : raw[IW-1:0];

    assign gate_ang = ang[GATE_CH];
    always_comb begin
        gate_mag = gate_ang;
        if (gate_ang[OW-1]) begin
            gate_mag = (gate_ang == ANG_MIN) ? ANG_MAX : -gate_ang;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ch         <= '0;
            smp_rate   <= '0;
            smp_accel  <= '0;
            prod       <= '0;
            cal_cnt    <= '0;
            out_vld_r  <= 1'b0;
            zeroed_r   <= 1'b0;
            cal_busy_r <= 1'b0;
            overrun_r  <= 1'b0;
            sat_r      <= '0;
            for (int c = 0; c < NCH; c++) begin
                integ[c] <= '0;
                ang[c]   <= '0;
                off[c]   <= OFFSET_INIT;
                sum[c]   <= '0;
            end
        end else begin
            out_vld_r <= 1'b0;
            if (bus.vld && state != S_IDLE) begin
                overrun_r <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (bus.vld) begin
                        smp_rate  <= bus.rate;
                        smp_accel <= bus.accel;
                        ch        <= '0;
                        state     <= S_MUL;
                    end
                end
                S_MUL: begin
                    prod  <= PW'(cur_accel) * PW'(GAIN_S);
                    state <= S_UPD;
                end
                S_UPD: begin
                    if (!cal_busy_r) begin
                        integ[ch] <= nxt;
                        ang[ch]   <= nxt[IW-1:SHIFT];
                        if (clamp) begin
                            sat_r[ch] <= 1'b1;
                        end
                    end
                    if (ch == CW'(NCH-1)) begin
                        state <= S_DONE;
                    end else begin
                        ch    <= ch + CW'(1);
                        state <= S_MUL;
                    end
                end
                S_DONE: begin
                    out_vld_r <= 1'b1;
                    state     <= S_IDLE;
                    if (cal_busy_r) begin
                        if (cal_cnt == CAL_N) begin
                            for (int c = 0; c < NCH; c++) begin
                                off[c] <= DW'(sum[c] >>> CAL_LOG);
                            end
                            cal_busy_r <= 1'b0;
                        end
                    end else if (gate_mag > THR_HI) begin
                        zeroed_r <= 1'b1;
                    end else if (gate_mag < THR_LO) begin
                        zeroed_r <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
            // A same-cycle cal_start restarts accumulation, counting an accepted sample as the first.
            if (bus.cal_start) begin
                cal_busy_r <= 1'b1;
                cal_cnt    <= accept ? CNT_ONE : '0;
                for (int c = 0; c < NCH; c++) begin
                    sum[c] <= accept ? SW'($signed(bus.rate[c*DW +: DW])) : '0;
                end
            end else if (accept && cal_busy_r) begin
                cal_cnt <= cal_cnt + CNT_ONE;
                for (int c = 0; c < NCH; c++) begin
                    sum[c] <= sum[c] + SW'($signed(bus.rate[c*DW +: DW]));
                end
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_out
        if (c == ZERO_CH) begin : g_zero
            assign bus.angle[c*OW +: OW] = zeroed_r ? '0 : ang[c];
        end else begin : g_pass
            assign bus.angle[c*OW +: OW] = ang[c];
        end
    end

    assign bus.out_vld  = out_vld_r;
    assign bus.zeroed   = zeroed_r;
    assign bus.cal_busy = cal_busy_r;
    assign bus.sat      = sat_r;
    assign bus.overrun  = overrun_r;
endmodule
